// File: rtl/tt_vpu_ovi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : tt_vpu_ovi_pkg                                           |
// | Purpose   : Shared queue depth, field widths, entry-state encoding   |
// |             and issue-entry record for the OVI issue controller.     |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package tt_vpu_ovi_pkg;

  localparam int OVI_Q_DEPTH  = 8;
  localparam int OVI_PTR_W    = $clog2(OVI_Q_DEPTH);
  localparam int OVI_CNT_W    = $clog2(OVI_Q_DEPTH + 1);

  localparam int OVI_INST_W   = 32;
  localparam int OVI_SB_W     = 5;
  localparam int OVI_SCALAR_W = 64;
  localparam int OVI_VCSR_W   = 40;
  localparam int OVI_FFLAGS_W = 5;
  localparam int OVI_DEST_W   = 64;
  localparam int OVI_VSTART_W = 14;

  // Lifecycle of a queued instruction: waiting for dispatch resolution,
  // cleared to execute, or squashed by the core.
  typedef enum logic [1:0] {
    ENT_PEND   = 2'd0,
    ENT_SENIOR = 2'd1,
    ENT_KILLED = 2'd2
  } ovi_ent_state_e;

  typedef struct packed {
    logic [OVI_INST_W-1:0]   inst;
    logic [OVI_SB_W-1:0]     sb_id;
    logic [OVI_SCALAR_W-1:0] scalar;
    logic [OVI_VCSR_W-1:0]   vcsr;
    ovi_ent_state_e          state;
  } ovi_issue_entry_t;

endpackage
`default_nettype wire

// File: rtl/tt_vpu_ovi_issue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tt_vpu_ovi_issue_fifo                                    |
// | Purpose   : Circular issue queue with head (pop), tail (push) and    |
// |             resolve pointers; the resolve pointer walks the PEND     |
// |             entries in issue order.                                  |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tt_vpu_ovi_issue_fifo
  import tt_vpu_ovi_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  ovi_issue_entry_t     push_entry,
  input  logic                 pop,
  input  logic                 resolve,
  input  logic                 resolve_kill,
  output ovi_issue_entry_t     head_entry,
  output logic [OVI_SB_W-1:0]  res_sb_id,
  output logic [OVI_CNT_W-1:0] count,
  output logic [OVI_CNT_W-1:0] unres_count
);

  ovi_issue_entry_t       mem [OVI_Q_DEPTH];
  logic [OVI_PTR_W-1:0]   head_ptr;
  logic [OVI_PTR_W-1:0]   tail_ptr;
  logic [OVI_PTR_W-1:0]   res_ptr;

  assign head_entry = mem[head_ptr];
  assign res_sb_id  = mem[res_ptr].sb_id;

  // Entry storage, pointers and occupancy; depth is a power of two so the
  // pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < OVI_Q_DEPTH; i++) begin
        mem[i] <= '0;
      end
      head_ptr    <= '0;
      tail_ptr    <= '0;
      res_ptr     <= '0;
      count       <= '0;
      unres_count <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= push_entry;
        tail_ptr      <= tail_ptr + 1'b1;
      end
      if (resolve) begin
        mem[res_ptr].state <= resolve_kill ? ENT_KILLED : ENT_SENIOR;
        res_ptr            <= res_ptr + 1'b1;
      end
      if (pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({push, resolve})
        2'b10:   unres_count <= unres_count + 1'b1;
        2'b01:   unres_count <= unres_count - 1'b1;
        default: unres_count <= unres_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tt_vpu_ovi_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tt_vpu_ovi_issue_ctrl                                    |
// | Purpose   : OVI issue/dispatch/completion controller for the vector  |
// |             unit: queues issue beats, applies dispatch resolution,   |
// |             hands SENIOR entries to execution, returns credits and   |
// |             registers completions.                                   |
// | Options   : TT_VPU_OVI_PROTOCOL_CHECK_EN enables the sticky          |
// |             err_protocol checker (tied 0 otherwise).                 |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tt_vpu_ovi_issue_ctrl
  import tt_vpu_ovi_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    issue_valid,
  input  logic [OVI_INST_W-1:0]   issue_inst,
  input  logic [OVI_SB_W-1:0]     issue_sb_id,
  input  logic [OVI_SCALAR_W-1:0] issue_scalar_opnd,
  input  logic [OVI_VCSR_W-1:0]   issue_vcsr,
  output logic                    issue_credit,
  input  logic [OVI_SB_W-1:0]     dispatch_sb_id,
  input  logic                    dispatch_next_senior,
  input  logic                    dispatch_kill,
  output logic                    exe_valid,
  input  logic                    exe_ready,
  output logic [OVI_INST_W-1:0]   exe_inst,
  output logic [OVI_SB_W-1:0]     exe_sb_id,
  output logic [OVI_SCALAR_W-1:0] exe_scalar_opnd,
  output logic [OVI_VCSR_W-1:0]   exe_vcsr,
  input  logic                    exe_done_valid,
  input  logic [OVI_SB_W-1:0]     exe_done_sb_id,
  input  logic [OVI_FFLAGS_W-1:0] exe_done_fflags,
  input  logic [OVI_DEST_W-1:0]   exe_done_dest_reg,
  input  logic                    exe_done_vxsat,
  input  logic [OVI_VSTART_W-1:0] exe_done_vstart,
  input  logic                    exe_done_illegal,
  output logic                    completed_valid,
  output logic [OVI_SB_W-1:0]     completed_sb_id,
  output logic [OVI_FFLAGS_W-1:0] completed_fflags,
  output logic [OVI_DEST_W-1:0]   completed_dest_reg,
  output logic                    completed_vxsat,
  output logic [OVI_VSTART_W-1:0] completed_vstart,
  output logic                    completed_illegal,
  output logic                    err_protocol
);

  ovi_issue_entry_t       head_entry;
  ovi_issue_entry_t       push_entry;
  logic [OVI_SB_W-1:0]    res_sb_id;
  logic [OVI_CNT_W-1:0]   count;
  logic [OVI_CNT_W-1:0]   unres_count;
  logic                   q_nonempty;
  logic                   q_full;
  logic                   push;
  logic                   pop;
  logic                   res_req;
  logic                   res_ok;

  assign q_nonempty = (count != '0);
  assign q_full     = (count == OVI_CNT_W'(OVI_Q_DEPTH));

  // A full queue still accepts a beat when a slot frees in the same cycle.
  assign pop  = q_nonempty && ((head_entry.state == ENT_SENIOR && exe_ready) ||
                               (head_entry.state == ENT_KILLED));
  assign push = issue_valid && (!q_full || pop);

  // Resolution only targets entries stored before this cycle, in order.
  assign res_req = dispatch_next_senior || dispatch_kill;
  assign res_ok  = res_req && (unres_count != '0) && (res_sb_id == dispatch_sb_id);

  assign push_entry = '{inst:   issue_inst,
                        sb_id:  issue_sb_id,
                        scalar: issue_scalar_opnd,
                        vcsr:   issue_vcsr,
                        state:  ENT_PEND};

  tt_vpu_ovi_issue_fifo u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .resolve      (res_ok),
    .resolve_kill (dispatch_kill),
    .head_entry   (head_entry),
    .res_sb_id    (res_sb_id),
    .count        (count),
    .unres_count  (unres_count)
  );

  assign exe_valid       = q_nonempty && (head_entry.state == ENT_SENIOR);
  assign exe_inst        = head_entry.inst;
  assign exe_sb_id       = head_entry.sb_id;
  assign exe_scalar_opnd = head_entry.scalar;
  assign exe_vcsr        = head_entry.vcsr;

  // One credit pulse the cycle after each freed slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) issue_credit <= 1'b0;
    else          issue_credit <= pop;
  end

  // Completion beat forwarded with one cycle of latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      completed_valid    <= 1'b0;
      completed_sb_id    <= '0;
      completed_fflags   <= '0;
      completed_dest_reg <= '0;
      completed_vxsat    <= 1'b0;
      completed_vstart   <= '0;
      completed_illegal  <= 1'b0;
    end else begin
      completed_valid <= exe_done_valid;
      if (exe_done_valid) begin
        completed_sb_id    <= exe_done_sb_id;
        completed_fflags   <= exe_done_fflags;
        completed_dest_reg <= exe_done_dest_reg;
        completed_vxsat    <= exe_done_vxsat;
        completed_vstart   <= exe_done_vstart;
        completed_illegal  <= exe_done_illegal;
      end
    end
  end

`ifdef TT_VPU_OVI_PROTOCOL_CHECK_EN
  logic proto_evt;
  assign proto_evt = (issue_valid && !push) ||
                     (res_req && !res_ok) ||
                     (dispatch_next_senior && dispatch_kill);

  // Sticky protocol-violation flag: overflow, bad resolution, conflicting resolve.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       err_protocol <= 1'b0;
    else if (proto_evt) err_protocol <= 1'b1;
  end
`else
  assign err_protocol = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tt_vpu_ovi_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_tt_vpu_ovi_issue_ctrl                                 |
// | Purpose   : Directed self-checking bench for tt_vpu_ovi_issue_ctrl.  |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_tt_vpu_ovi_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic [31:0] issue_inst;
  logic [4:0]  issue_sb_id;
  logic [63:0] issue_scalar_opnd;
  logic [39:0] issue_vcsr;
  logic        issue_credit;
  logic [4:0]  dispatch_sb_id;
  logic        dispatch_next_senior;
  logic        dispatch_kill;
  logic        exe_valid;
  logic        exe_ready;
  logic [31:0] exe_inst;
  logic [4:0]  exe_sb_id;
  logic [63:0] exe_scalar_opnd;
  logic [39:0] exe_vcsr;
  logic        exe_done_valid;
  logic [4:0]  exe_done_sb_id;
  logic [4:0]  exe_done_fflags;
  logic [63:0] exe_done_dest_reg;
  logic        exe_done_vxsat;
  logic [13:0] exe_done_vstart;
  logic        exe_done_illegal;
  logic        completed_valid;
  logic [4:0]  completed_sb_id;
  logic [4:0]  completed_fflags;
  logic [63:0] completed_dest_reg;
  logic        completed_vxsat;
  logic [13:0] completed_vstart;
  logic        completed_illegal;
  logic        err_protocol;

  int checks = 0;
  int errors = 0;
  int credits;
  logic saw_exe;

`ifdef TT_VPU_OVI_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  tt_vpu_ovi_issue_ctrl dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .issue_valid          (issue_valid),
    .issue_inst           (issue_inst),
    .issue_sb_id          (issue_sb_id),
    .issue_scalar_opnd    (issue_scalar_opnd),
    .issue_vcsr           (issue_vcsr),
    .issue_credit         (issue_credit),
    .dispatch_sb_id       (dispatch_sb_id),
    .dispatch_next_senior (dispatch_next_senior),
    .dispatch_kill        (dispatch_kill),
    .exe_valid            (exe_valid),
    .exe_ready            (exe_ready),
    .exe_inst             (exe_inst),
    .exe_sb_id            (exe_sb_id),
    .exe_scalar_opnd      (exe_scalar_opnd),
    .exe_vcsr             (exe_vcsr),
    .exe_done_valid       (exe_done_valid),
    .exe_done_sb_id       (exe_done_sb_id),
    .exe_done_fflags      (exe_done_fflags),
    .exe_done_dest_reg    (exe_done_dest_reg),
    .exe_done_vxsat       (exe_done_vxsat),
    .exe_done_vstart      (exe_done_vstart),
    .exe_done_illegal     (exe_done_illegal),
    .completed_valid      (completed_valid),
    .completed_sb_id      (completed_sb_id),
    .completed_fflags     (completed_fflags),
    .completed_dest_reg   (completed_dest_reg),
    .completed_vxsat      (completed_vxsat),
    .completed_vstart     (completed_vstart),
    .completed_illegal    (completed_illegal),
    .err_protocol         (err_protocol)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid          = 1'b0;
    dispatch_next_senior = 1'b0;
    dispatch_kill        = 1'b0;
    exe_done_valid       = 1'b0;
  endtask

  task automatic drive_issue(input logic [4:0] sb);
    issue_valid       = 1'b1;
    issue_sb_id       = sb;
    issue_inst        = 32'h1000_0000 | 32'(sb);
    issue_scalar_opnd = 64'hCAFE_0000_0000_0000 | 64'(sb);
    issue_vcsr        = 40'h12_3400_0000 | 40'(sb);
  endtask

  task automatic resolve(input logic [4:0] sb, input logic sen, input logic kil);
    dispatch_sb_id       = sb;
    dispatch_next_senior = sen;
    dispatch_kill        = kil;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    exe_ready = 1'b0;
    dispatch_sb_id = '0;
    issue_inst = '0; issue_sb_id = '0; issue_scalar_opnd = '0; issue_vcsr = '0;
    exe_done_sb_id = '0; exe_done_fflags = '0; exe_done_dest_reg = '0;
    exe_done_vxsat = 1'b0; exe_done_vstart = '0; exe_done_illegal = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_exe_valid", 64'(exe_valid), 64'd0);
    chk("rst_credit", 64'(issue_credit), 64'd0);
    chk("rst_completed", 64'(completed_valid), 64'd0);
    chk("rst_err", 64'(err_protocol), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("rel_credit", 64'(issue_credit), 64'd0);

    // Basic issue -> senior -> exe -> credit
    exe_ready = 1'b1;
    drive_issue(5'd3);
    tick();
    idle();
    chk("pend_no_exe", 64'(exe_valid), 64'd0);
    resolve(5'd3, 1'b1, 1'b0);
    tick();
    idle();
    chk("b_exe_valid", 64'(exe_valid), 64'd1);
    chk("b_exe_sb", 64'(exe_sb_id), 64'd3);
    chk("b_exe_inst", 64'(exe_inst), 64'h1000_0003);
    chk("b_credit_early", 64'(issue_credit), 64'd0);
    tick();
    chk("b_credit", 64'(issue_credit), 64'd1);
    chk("b_exe_gone", 64'(exe_valid), 64'd0);
    tick();
    chk("b_credit_pulse", 64'(issue_credit), 64'd0);

    // Kill then senior
    drive_issue(5'd1);
    tick();
    drive_issue(5'd2);
    tick();
    idle();
    resolve(5'd1, 1'b0, 1'b1);
    tick();
    idle();
    chk("k_no_exe", 64'(exe_valid), 64'd0);
    resolve(5'd2, 1'b1, 1'b0);
    tick();
    idle();
    chk("k_credit1", 64'(issue_credit), 64'd1);
    chk("k_exe_valid", 64'(exe_valid), 64'd1);
    chk("k_exe_sb", 64'(exe_sb_id), 64'd2);
    tick();
    chk("k_credit2", 64'(issue_credit), 64'd1);
    chk("k_exe_gone", 64'(exe_valid), 64'd0);
    tick();
    chk("k_credit_end", 64'(issue_credit), 64'd0);

    // Back-pressure: exe fields stable while exe_ready is low
    exe_ready = 1'b0;
    drive_issue(5'd9);
    tick();
    idle();
    resolve(5'd9, 1'b1, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 64'(exe_valid), 64'd1);
      chk("bp_sb", 64'(exe_sb_id), 64'd9);
      chk("bp_scalar", exe_scalar_opnd, 64'hCAFE_0000_0000_0009);
      chk("bp_vcsr", 64'(exe_vcsr), 64'h12_3400_0009);
      chk("bp_credit", 64'(issue_credit), 64'd0);
      tick();
    end
    exe_ready = 1'b1;
    chk("bp_valid_hs", 64'(exe_valid), 64'd1);
    tick();
    chk("bp_credit_after", 64'(issue_credit), 64'd1);
    tick();
    chk("clean_err", 64'(err_protocol), 64'd0);

    // Overflow, then full+pop+push, then drain by kills (pointers wrap)
    exe_ready = 1'b0;
    saw_exe = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive_issue(5'(10 + k));
      tick();
    end
    idle();
    chk("ovf_count", 64'(dut.u_fifo.count), 64'd8);
    chk("ovf_err", 64'(err_protocol), 64'(EXP_ERR));
    credits = 0;
    resolve(5'd10, 1'b0, 1'b1);
    tick();
    credits += int'(issue_credit);
    drive_issue(5'd18);
    resolve(5'd11, 1'b0, 1'b1);
    tick();
    credits += int'(issue_credit);
    issue_valid = 1'b0;
    chk("fpp_count", 64'(dut.u_fifo.count), 64'd8);
    for (int k = 12; k <= 18; k++) begin
      resolve(5'(k), 1'b0, 1'b1);
      saw_exe = saw_exe | exe_valid;
      tick();
      credits += int'(issue_credit);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      saw_exe = saw_exe | exe_valid;
      tick();
      credits += int'(issue_credit);
    end
    chk("drain_credits", 64'(credits), 64'd9);
    chk("drain_count", 64'(dut.u_fifo.count), 64'd0);
    chk("drain_no_exe", 64'(saw_exe), 64'd0);

    // Mismatched sb_id on resolve is ignored
    do_reset();
    chk("rst2_err", 64'(err_protocol), 64'd0);
    drive_issue(5'd6);
    tick();
    idle();
    resolve(5'd4, 1'b1, 1'b0);
    tick();
    idle();
    chk("mm_no_exe", 64'(exe_valid), 64'd0);
    chk("mm_err", 64'(err_protocol), 64'(EXP_ERR));
    exe_ready = 1'b1;
    resolve(5'd6, 1'b1, 1'b0);
    tick();
    idle();
    chk("mm_exe_valid", 64'(exe_valid), 64'd1);
    chk("mm_exe_sb", 64'(exe_sb_id), 64'd6);
    tick();
    chk("mm_credit", 64'(issue_credit), 64'd1);

    // Senior and kill together: kill wins
    do_reset();
    drive_issue(5'd5);
    tick();
    idle();
    resolve(5'd5, 1'b1, 1'b1);
    tick();
    idle();
    chk("sk_no_exe", 64'(exe_valid), 64'd0);
    chk("sk_err", 64'(err_protocol), 64'(EXP_ERR));
    tick();
    chk("sk_credit", 64'(issue_credit), 64'd1);
    chk("sk_count", 64'(dut.u_fifo.count), 64'd0);

    // Completion register
    exe_done_valid = 1'b1;
    exe_done_sb_id = 5'd7;
    exe_done_fflags = 5'h1;
    exe_done_dest_reg = 64'h0123_4567_89AB_CDEF;
    exe_done_vstart = 14'h2A;
    exe_done_vxsat = 1'b1;
    exe_done_illegal = 1'b0;
    tick();
    idle();
    chk("cmp_valid", 64'(completed_valid), 64'd1);
    chk("cmp_sb", 64'(completed_sb_id), 64'd7);
    chk("cmp_fflags", 64'(completed_fflags), 64'h1);
    chk("cmp_dest", completed_dest_reg, 64'h0123_4567_89AB_CDEF);
    chk("cmp_vstart", 64'(completed_vstart), 64'h2A);
    chk("cmp_vxsat", 64'(completed_vxsat), 64'd1);
    tick();
    chk("cmp_pulse", 64'(completed_valid), 64'd0);

    // Reset while exe and completion beats are in flight
    exe_ready = 1'b0;
    drive_issue(5'd20);
    tick();
    idle();
    resolve(5'd20, 1'b1, 1'b0);
    tick();
    idle();
    exe_done_valid = 1'b1;
    exe_done_sb_id = 5'd21;
    tick();
    idle();
    chk("mid_exe_valid", 64'(exe_valid), 64'd1);
    chk("mid_cmp_valid", 64'(completed_valid), 64'd1);
    reset_n = 1'b0;
    #2;
    chk("async_exe_valid", 64'(exe_valid), 64'd0);
    chk("async_cmp_valid", 64'(completed_valid), 64'd0);
    chk("async_count", 64'(dut.u_fifo.count), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_credit", 64'(issue_credit), 64'd0);
    chk("post_cmp", 64'(completed_valid), 64'd0);
    tick();
    chk("post_credit2", 64'(issue_credit), 64'd0);
    chk("post_exe", 64'(exe_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
